// File: rtl/adat_pkg.sv
// Shared types and frame-geometry constants for the ADAT deframer.
package adat_pkg;

    localparam int unsigned ADAT_CHANNELS           = 8;
    localparam int unsigned ADAT_NIBBLES_PER_SAMPLE = 6;
    localparam int unsigned ADAT_SAMPLE_WIDTH       = 24;
    localparam int unsigned ADAT_USER_BITS          = 4;

    typedef enum logic [2:0] {
        StHunt   = 3'd0,
        StUser   = 3'd1,
        StSep    = 3'd2,
        StNibble = 3'd3,
        StGap    = 3'd4
    } deframer_state_e;

endpackage

// File: rtl/adat_frame_deframer.sv
// ADAT frame deframer: locks to the sync gap, splits each frame into user bits
// and eight 24-bit samples, and flags structural errors and input stalls.
module adat_frame_deframer
    import adat_pkg::*;
#(
    parameter int unsigned SYNC_ZEROS_MIN = 10,
    parameter int unsigned SYNC_ZEROS_MAX = 11,
    parameter int unsigned STALL_TIMEOUT  = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_i,
    input  logic        valid_i,
    input  logic        sync_i,
    output logic [23:0] sample_o,
    output logic [2:0]  channel_o,
    output logic        sample_valid_o,
    output logic [3:0]  user_bits_o,
    output logic        frame_valid_o,
    output logic        locked_o,
    output logic        frame_error_o
);

    localparam int unsigned ZCNT_W  = 5;
    localparam int unsigned STALL_W = $clog2(STALL_TIMEOUT + 1);
    localparam logic [ZCNT_W-1:0] ZMIN = ZCNT_W'(SYNC_ZEROS_MIN);
    localparam logic [ZCNT_W-1:0] ZMAX = ZCNT_W'(SYNC_ZEROS_MAX);
    localparam logic [2:0] LAST_NIB = 3'(ADAT_NIBBLES_PER_SAMPLE - 1);
    localparam logic [2:0] LAST_CH  = 3'(ADAT_CHANNELS - 1);

    deframer_state_e        state_q;
    logic [ZCNT_W-1:0]      zcnt_q;
    logic [ZCNT_W-1:0]      zcnt_inc_d;
    logic                   sync_last_q;
    logic [1:0]             bit_cnt_q;
    logic [2:0]             nib_idx_q;
    logic [2:0]             ch_idx_q;
    logic                   last_nib_q;
    logic [ADAT_SAMPLE_WIDTH-2:0] sample_shift_q;
    logic [ADAT_USER_BITS-1:0]    user_shadow_q;
    logic [STALL_W-1:0]     stall_cnt_q;

    logic in_frame;
    logic gap_over;
    logic struct_err;
    logic stall_hit;

    assign zcnt_inc_d = (&zcnt_q) ? zcnt_q : zcnt_q + ZCNT_W'(1);
    assign in_frame   = (state_q == StUser) || (state_q == StSep) || (state_q == StNibble);
    assign gap_over   = (state_q == StGap) && !data_i && (zcnt_inc_d > ZMAX);
    assign struct_err = valid_i && ((in_frame && sync_i)
                                 || (state_q == StSep && !data_i)
                                 || (state_q == StGap && data_i && zcnt_q < ZMIN)
                                 || gap_over);
    assign stall_hit  = (state_q != StHunt) && !valid_i
                     && (stall_cnt_q == STALL_W'(STALL_TIMEOUT - 1));

    // Consecutive idle cycles while locked
    always_ff @(posedge clk_i) begin
        if (rst_i || valid_i || state_q == StHunt || stall_hit) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_q + STALL_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= StHunt;
            zcnt_q         <= '0;
            sync_last_q    <= 1'b0;
            bit_cnt_q      <= '0;
            nib_idx_q      <= '0;
            ch_idx_q       <= '0;
            last_nib_q     <= 1'b0;
            sample_shift_q <= '0;
            user_shadow_q  <= '0;
            sample_o       <= '0;
            channel_o      <= '0;
            sample_valid_o <= 1'b0;
            user_bits_o    <= '0;
            frame_valid_o  <= 1'b0;
            locked_o       <= 1'b0;
            frame_error_o  <= 1'b0;
        end else begin
            sample_valid_o <= 1'b0;
            frame_valid_o  <= 1'b0;
            frame_error_o  <= 1'b0;
            if (valid_i && !data_i) begin
                sync_last_q <= sync_i;
            end

            if (stall_hit || struct_err) begin
                // An over-long gap keeps its count so the next '1' can re-lock at once
                frame_error_o <= 1'b1;
                locked_o      <= 1'b0;
                state_q       <= StHunt;
                if (gap_over) begin
                    zcnt_q <= zcnt_inc_d;
                end else if (valid_i && !data_i) begin
                    zcnt_q <= ZCNT_W'(1);
                end else begin
                    zcnt_q <= '0;
                end
            end else if (valid_i) begin
                unique case (state_q)
                    StHunt: begin
                        if (!data_i) begin
                            zcnt_q <= zcnt_inc_d;
                        end else if (zcnt_q >= ZMIN && sync_last_q) begin
                            state_q    <= StUser;
                            locked_o   <= 1'b1;
                            zcnt_q     <= '0;
                            bit_cnt_q  <= '0;
                            nib_idx_q  <= '0;
                            ch_idx_q   <= '0;
                            last_nib_q <= 1'b0;
                        end else begin
                            zcnt_q <= '0;
                        end
                    end
                    StUser: begin
                        user_shadow_q <= {user_shadow_q[ADAT_USER_BITS-2:0], data_i};
                        bit_cnt_q     <= bit_cnt_q + 2'd1;
                        if (bit_cnt_q == 2'd3) begin
                            state_q <= StSep;
                        end
                    end
                    StSep: begin
                        bit_cnt_q <= '0;
                        if (last_nib_q) begin
                            state_q <= StGap;
                            zcnt_q  <= '0;
                        end else begin
                            state_q <= StNibble;
                        end
                    end
                    StNibble: begin
                        sample_shift_q <= {sample_shift_q[ADAT_SAMPLE_WIDTH-3:0], data_i};
                        bit_cnt_q      <= bit_cnt_q + 2'd1;
                        if (bit_cnt_q == 2'd3) begin
                            state_q <= StSep;
                            if (nib_idx_q == LAST_NIB) begin
                                nib_idx_q      <= '0;
                                ch_idx_q       <= ch_idx_q + 3'd1;
                                sample_o       <= {sample_shift_q, data_i};
                                channel_o      <= ch_idx_q;
                                sample_valid_o <= 1'b1;
                                last_nib_q     <= (ch_idx_q == LAST_CH);
                            end else begin
                                nib_idx_q <= nib_idx_q + 3'd1;
                            end
                        end
                    end
                    StGap: begin
                        if (!data_i) begin
                            zcnt_q <= zcnt_inc_d;
                        end else begin
                            frame_valid_o <= 1'b1;
                            user_bits_o   <= user_shadow_q;
                            state_q       <= StUser;
                            zcnt_q        <= '0;
                            bit_cnt_q     <= '0;
                            nib_idx_q     <= '0;
                            ch_idx_q      <= '0;
                            last_nib_q    <= 1'b0;
                        end
                    end
                    default: begin
                        state_q  <= StHunt;
                        locked_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adat_frame_deframer.sv
// Self-checking bench for adat_frame_deframer: builds ADAT bit streams from
// frame-level descriptions and annotates each bit with the expected outputs.
module tb_adat_frame_deframer;

    localparam int MIN_Z = 10;
    localparam int MAX_Z = 11;
    localparam int STALL = 8;

    logic        clk_i = 1'b0;
    logic        rst_i, data_i, valid_i, sync_i;
    logic [23:0] sample_o;
    logic [2:0]  channel_o;
    logic        sample_valid_o, frame_valid_o, locked_o, frame_error_o;
    logic [3:0]  user_bits_o;

    always #5 clk_i = ~clk_i;

    adat_frame_deframer #(
        .SYNC_ZEROS_MIN(MIN_Z), .SYNC_ZEROS_MAX(MAX_Z), .STALL_TIMEOUT(STALL)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .valid_i(valid_i), .sync_i(sync_i),
        .sample_o(sample_o), .channel_o(channel_o), .sample_valid_o(sample_valid_o),
        .user_bits_o(user_bits_o), .frame_valid_o(frame_valid_o), .locked_o(locked_o),
        .frame_error_o(frame_error_o)
    );

    // One clock cycle of stimulus plus the outputs expected right after its edge
    typedef struct {
        bit          r, v, d, s;
        bit          e_sv, e_fv, e_err, e_lock;
        logic [23:0] e_smp;
        logic [2:0]  e_ch;
        logic [3:0]  e_user;
    } item_t;

    item_t       q[$];
    bit          m_lock;
    logic [3:0]  m_user, m_shadow;
    logic [23:0] fs [8];
    int          checks = 0, failures = 0;
    int          n_sv, n_fv, n_err, n_unlock;

    task automatic push(input bit v, input bit d, input bit s, input bit sv, input bit fv,
                        input bit err, input logic [23:0] smp, input logic [2:0] ch);
        item_t it;
        if (err) m_lock = 1'b0;
        it.r = 1'b0; it.v = v; it.d = d; it.s = s;
        it.e_sv = sv; it.e_fv = fv; it.e_err = err; it.e_lock = m_lock;
        it.e_smp = smp; it.e_ch = ch; it.e_user = m_user;
        q.push_back(it);
    endtask

    task automatic push_reset();
        item_t it;
        m_lock = 1'b0; m_user = 4'h0;
        it.r = 1'b1; it.v = 1'b0; it.d = 1'b0; it.s = 1'b0;
        it.e_sv = 1'b0; it.e_fv = 1'b0; it.e_err = 1'b0; it.e_lock = 1'b0;
        it.e_smp = 24'h0; it.e_ch = 3'h0; it.e_user = 4'h0;
        q.push_back(it);
    endtask

    task automatic add_idle(input int n);
        for (int k = 1; k <= n; k++) push(0, 0, 0, 0, 0, m_lock && (k == STALL), 24'h0, 3'h0);
    endtask

    // Zero run; the decoder flags sync from the 8th zero. Inside a gap, a run past MAX_Z errors.
    task automatic add_zeros(input int n);
        for (int k = 1; k <= n; k++) push(1, 0, k >= 8, 0, 0, m_lock && (k == MAX_Z + 1), 24'h0, 3'h0);
    endtask

    // The '1' ending a zero run of length nz: closes a frame when locked, locks when hunting
    task automatic add_sync_one(input int nz);
        bit fv = 1'b0, err = 1'b0;
        if (m_lock) begin
            if (nz >= MIN_Z && nz <= MAX_Z) begin fv = 1'b1; m_user = m_shadow; end
            else err = 1'b1;
        end else if (nz >= MIN_Z) begin
            m_lock = 1'b1;
        end
        push(1, 1, 0, 0, fv, err, 24'h0, 3'h0);
    endtask

    // User bits, 48 separator+nibble groups carrying fs[], trailing '1'
    task automatic add_body(input logic [3:0] user, input int bad_sep, input int stall_at,
                            input int stall_len, input int rst_ch);
        for (int b = 0; b < 4; b++) push(1, user[3-b], 0, 0, 0, 0, 24'h0, 3'h0);
        m_shadow = user;
        for (int ch = 0; ch < 8; ch++) begin
            for (int nib = 0; nib < 6; nib++) begin
                int sep = ch * 6 + nib;
                if (ch == rst_ch && nib == 2) begin push_reset(); return; end
                push(1, sep != bad_sep, 0, 0, 0, (sep == bad_sep) && m_lock, 24'h0, 3'h0);
                for (int b = 0; b < 4; b++) begin
                    push(1, fs[ch][23 - nib*4 - b], 0, (nib == 5 && b == 3) && m_lock, 0, 0,
                         fs[ch], 3'(ch));
                    if (sep == stall_at && b == 1) add_idle(stall_len);
                end
            end
        end
        push(1, 1, 0, 0, 0, 0, 24'h0, 3'h0);
    endtask

    task automatic drive(input item_t it);
        rst_i = it.r; valid_i = it.v; data_i = it.d; sync_i = it.s;
        @(posedge clk_i);
        #1;
    endtask

    task automatic rand_samples();
        for (int c = 0; c < 8; c++) fs[c] = 24'($urandom);
    endtask

    task automatic test_reset();
        q.delete();
        push_reset();
        add_idle(3);
        for (int i = 0; i < q.size(); i++) begin
            drive(q[i]);
            checks++;
            if ({sample_valid_o, frame_valid_o, frame_error_o, locked_o, user_bits_o, channel_o, sample_o}
                !== {8'h00, 3'h0, 24'h0})
                begin failures++; $display("FAIL reset_outputs item %0d: got sv/fv/err/lock/user/ch/smp=%b %h required all zero",
                    i, {sample_valid_o, frame_valid_o, frame_error_o, locked_o, user_bits_o, channel_o}, sample_o); end
        end
    endtask

    task automatic test_clean_frame();
        q.delete(); n_sv = 0; n_fv = 0;
        push_reset();
        for (int c = 0; c < 8; c++) fs[c] = 24'(c + 1);
        add_zeros(12); add_sync_one(12);
        add_body(4'b1010, -1, -1, 0, -1);
        add_zeros(10); add_sync_one(10);
        for (int i = 0; i < q.size(); i++) begin
            drive(q[i]);
            n_sv += int'(sample_valid_o); n_fv += int'(frame_valid_o);
            checks++;
            if ({sample_valid_o, frame_valid_o, frame_error_o, locked_o, user_bits_o} !== {q[i].e_sv, q[i].e_fv, q[i].e_err, q[i].e_lock, q[i].e_user})
                begin failures++; $display("FAIL clean_flags item %0d: got sv/fv/err/lock/user=%b required %b", i,
                    {sample_valid_o, frame_valid_o, frame_error_o, locked_o, user_bits_o}, {q[i].e_sv, q[i].e_fv, q[i].e_err, q[i].e_lock, q[i].e_user}); end
            if (q[i].e_sv || q[i].r) begin
                checks++;
                if ({channel_o, sample_o} !== {q[i].e_ch, q[i].e_smp})
                    begin failures++; $display("FAIL clean_sample item %0d: got ch=%0d smp=%h required ch=%0d smp=%h", i, channel_o, sample_o, q[i].e_ch, q[i].e_smp); end
            end
        end
        checks++;
        if (n_sv != 8 || n_fv != 1 || user_bits_o !== 4'b1010)
            begin failures++; $display("FAIL clean_totals: got sv=%0d fv=%0d user=%b required sv=8 fv=1 user=1010", n_sv, n_fv, user_bits_o); end
    endtask

    task automatic test_back_to_back();
        q.delete(); n_sv = 0; n_fv = 0; n_err = 0; n_unlock = 0;
        push_reset();
        add_zeros(12); add_sync_one(12);
        for (int f = 0; f < 3; f++) begin
            int gap = int'($urandom_range(MIN_Z, MAX_Z));
            for (int c = 0; c < 8; c++) fs[c] = ((f + c) % 2 == 0) ? 24'hFFFFFF : 24'h800000;
            add_body(4'($urandom), -1, -1, 0, -1);
            add_zeros(gap); add_sync_one(gap);
        end
        for (int i = 0; i < q.size(); i++) begin
            drive(q[i]);
            n_sv += int'(sample_valid_o); n_fv += int'(frame_valid_o); n_err += int'(frame_error_o);
            if (i > 13) n_unlock += int'(!locked_o);
            checks++;
            if ({sample_valid_o, frame_valid_o, frame_error_o, locked_o, user_bits_o} !== {q[i].e_sv, q[i].e_fv, q[i].e_err, q[i].e_lock, q[i].e_user})
                begin failures++; $display("FAIL b2b_flags item %0d: got sv/fv/err/lock/user=%b required %b", i,
                    {sample_valid_o, frame_valid_o, frame_error_o, locked_o, user_bits_o}, {q[i].e_sv, q[i].e_fv, q[i].e_err, q[i].e_lock, q[i].e_user}); end
            if (q[i].e_sv) begin
                checks++;
                if ({channel_o, sample_o} !== {q[i].e_ch, q[i].e_smp})
                    begin failures++; $display("FAIL b2b_sample item %0d: got ch=%0d smp=%h required ch=%0d smp=%h", i, channel_o, sample_o, q[i].e_ch, q[i].e_smp); end
            end
        end
        checks++;
        if (n_sv != 24 || n_fv != 3 || n_err != 0 || n_unlock != 0)
            begin failures++; $display("FAIL b2b_totals: got sv=%0d fv=%0d err=%0d unlocked=%0d required 24 3 0 0", n_sv, n_fv, n_err, n_unlock); end
    endtask

    task automatic test_bad_separator();
        q.delete(); n_sv = 0; n_fv = 0; n_err = 0;
        push_reset();
        rand_samples();
        add_zeros(12); add_sync_one(12);
        add_body(4'($urandom), 3 * 6 + 2, -1, 0, -1);
        rand_samples();
        add_zeros(12); add_sync_one(12);
        add_body(4'($urandom), -1, -1, 0, -1);
        add_zeros(10); add_sync_one(10);
        for (int i = 0; i < q.size(); i++) begin
            drive(q[i]);
            n_sv += int'(sample_valid_o); n_fv += int'(frame_valid_o); n_err += int'(frame_error_o);
            checks++;
            if ({sample_valid_o, frame_valid_o, frame_error_o, locked_o, user_bits_o} !== {q[i].e_sv, q[i].e_fv, q[i].e_err, q[i].e_lock, q[i].e_user})
                begin failures++; $display("FAIL badsep_flags item %0d: got sv/fv/err/lock/user=%b required %b", i,
                    {sample_valid_o, frame_valid_o, frame_error_o, locked_o, user_bits_o}, {q[i].e_sv, q[i].e_fv, q[i].e_err, q[i].e_lock, q[i].e_user}); end
            if (q[i].e_sv) begin
                checks++;
                if ({channel_o, sample_o} !== {q[i].e_ch, q[i].e_smp})
                    begin failures++; $display("FAIL badsep_sample item %0d: got ch=%0d smp=%h required ch=%0d smp=%h", i, channel_o, sample_o, q[i].e_ch, q[i].e_smp); end
            end
        end
        checks++;
        if (n_sv != 11 || n_fv != 1 || n_err != 1)
            begin failures++; $display("FAIL badsep_totals: got sv=%0d fv=%0d err=%0d required 11 1 1", n_sv, n_fv, n_err); end
    endtask

    task automatic test_gap_errors();
        q.delete(); n_fv = 0; n_err = 0;
        push_reset();
        rand_samples();
        add_zeros(12); add_sync_one(12);
        add_body(4'($urandom), -1, -1, 0, -1);
        add_zeros(9); add_sync_one(9);
        add_zeros(12); add_sync_one(12);
        add_body(4'($urandom), -1, -1, 0, -1);
        add_zeros(16); add_sync_one(16);
        rand_samples();
        add_body(4'($urandom), -1, -1, 0, -1);
        add_zeros(10); add_sync_one(10);
        for (int i = 0; i < q.size(); i++) begin
            drive(q[i]);
            n_fv += int'(frame_valid_o); n_err += int'(frame_error_o);
            checks++;
            if ({sample_valid_o, frame_valid_o, frame_error_o, locked_o, user_bits_o} !== {q[i].e_sv, q[i].e_fv, q[i].e_err, q[i].e_lock, q[i].e_user})
                begin failures++; $display("FAIL gap_flags item %0d: got sv/fv/err/lock/user=%b required %b", i,
                    {sample_valid_o, frame_valid_o, frame_error_o, locked_o, user_bits_o}, {q[i].e_sv, q[i].e_fv, q[i].e_err, q[i].e_lock, q[i].e_user}); end
            if (q[i].e_sv) begin
                checks++;
                if ({channel_o, sample_o} !== {q[i].e_ch, q[i].e_smp})
                    begin failures++; $display("FAIL gap_sample item %0d: got ch=%0d smp=%h required ch=%0d smp=%h", i, channel_o, sample_o, q[i].e_ch, q[i].e_smp); end
            end
        end
        checks++;
        if (n_fv != 1 || n_err != 2)
            begin failures++; $display("FAIL gap_totals: got fv=%0d err=%0d required 1 2", n_fv, n_err); end
    endtask

    task automatic test_stall();
        q.delete(); n_fv = 0; n_err = 0;
        push_reset();
        rand_samples();
        add_zeros(12); add_sync_one(12);
        add_body(4'($urandom), -1, int'($urandom_range(0, 47)), STALL - 1, -1);
        add_zeros(10); add_sync_one(10);
        add_body(4'($urandom), -1, int'($urandom_range(0, 47)), STALL, -1);
        rand_samples();
        add_zeros(12); add_sync_one(12);
        add_body(4'($urandom), -1, -1, 0, -1);
        add_zeros(11); add_sync_one(11);
        for (int i = 0; i < q.size(); i++) begin
            drive(q[i]);
            n_fv += int'(frame_valid_o); n_err += int'(frame_error_o);
            checks++;
            if ({sample_valid_o, frame_valid_o, frame_error_o, locked_o, user_bits_o} !== {q[i].e_sv, q[i].e_fv, q[i].e_err, q[i].e_lock, q[i].e_user})
                begin failures++; $display("FAIL stall_flags item %0d: got sv/fv/err/lock/user=%b required %b", i,
                    {sample_valid_o, frame_valid_o, frame_error_o, locked_o, user_bits_o}, {q[i].e_sv, q[i].e_fv, q[i].e_err, q[i].e_lock, q[i].e_user}); end
            if (q[i].e_sv) begin
                checks++;
                if ({channel_o, sample_o} !== {q[i].e_ch, q[i].e_smp})
                    begin failures++; $display("FAIL stall_sample item %0d: got ch=%0d smp=%h required ch=%0d smp=%h", i, channel_o, sample_o, q[i].e_ch, q[i].e_smp); end
            end
        end
        checks++;
        if (n_fv != 2 || n_err != 1)
            begin failures++; $display("FAIL stall_totals: got fv=%0d err=%0d required 2 1", n_fv, n_err); end
    endtask

    task automatic test_reset_mid_frame();
        q.delete(); n_fv = 0; n_err = 0;
        push_reset();
        rand_samples();
        add_zeros(12); add_sync_one(12);
        add_body(4'($urandom_range(1, 15)), -1, -1, 0, -1);
        add_zeros(10); add_sync_one(10);
        add_body(4'($urandom), -1, -1, 0, 5);
        rand_samples();
        add_zeros(12); add_sync_one(12);
        add_body(4'($urandom), -1, -1, 0, -1);
        add_zeros(11); add_sync_one(11);
        for (int i = 0; i < q.size(); i++) begin
            drive(q[i]);
            n_fv += int'(frame_valid_o); n_err += int'(frame_error_o);
            checks++;
            if ({sample_valid_o, frame_valid_o, frame_error_o, locked_o, user_bits_o} !== {q[i].e_sv, q[i].e_fv, q[i].e_err, q[i].e_lock, q[i].e_user})
                begin failures++; $display("FAIL rstmid_flags item %0d: got sv/fv/err/lock/user=%b required %b", i,
                    {sample_valid_o, frame_valid_o, frame_error_o, locked_o, user_bits_o}, {q[i].e_sv, q[i].e_fv, q[i].e_err, q[i].e_lock, q[i].e_user}); end
            if (q[i].e_sv || q[i].r) begin
                checks++;
                if ({channel_o, sample_o} !== {q[i].e_ch, q[i].e_smp})
                    begin failures++; $display("FAIL rstmid_sample item %0d: got ch=%0d smp=%h required ch=%0d smp=%h", i, channel_o, sample_o, q[i].e_ch, q[i].e_smp); end
            end
        end
        checks++;
        if (n_fv != 2 || n_err != 0)
            begin failures++; $display("FAIL rstmid_totals: got fv=%0d err=%0d required 2 0", n_fv, n_err); end
    endtask

    task automatic test_random_frames();
        q.delete(); n_sv = 0; n_err = 0;
        push_reset();
        add_zeros(int'($urandom_range(10, 20))); 
        add_sync_one(q.size() - 1);
        for (int f = 0; f < 4; f++) begin
            int gap = int'($urandom_range(MIN_Z, MAX_Z));
            rand_samples();
            add_body(4'($urandom), -1, int'($urandom_range(0, 47)), int'($urandom_range(0, STALL - 1)), -1);
            add_zeros(gap); add_sync_one(gap);
        end
        for (int i = 0; i < q.size(); i++) begin
            drive(q[i]);
            n_sv += int'(sample_valid_o); n_err += int'(frame_error_o);
            checks++;
            if ({sample_valid_o, frame_valid_o, frame_error_o, locked_o, user_bits_o} !== {q[i].e_sv, q[i].e_fv, q[i].e_err, q[i].e_lock, q[i].e_user})
                begin failures++; $display("FAIL rand_flags item %0d: got sv/fv/err/lock/user=%b required %b", i,
                    {sample_valid_o, frame_valid_o, frame_error_o, locked_o, user_bits_o}, {q[i].e_sv, q[i].e_fv, q[i].e_err, q[i].e_lock, q[i].e_user}); end
            if (q[i].e_sv) begin
                checks++;
                if ({channel_o, sample_o} !== {q[i].e_ch, q[i].e_smp})
                    begin failures++; $display("FAIL rand_sample item %0d: got ch=%0d smp=%h required ch=%0d smp=%h", i, channel_o, sample_o, q[i].e_ch, q[i].e_smp); end
            end
        end
        checks++;
        if (n_sv != 32 || n_err != 0)
            begin failures++; $display("FAIL rand_totals: got sv=%0d err=%0d required 32 0", n_sv, n_err); end
    endtask

    initial begin
        rst_i = 1'b1; valid_i = 1'b0; data_i = 1'b0; sync_i = 1'b0;
        m_lock = 1'b0; m_user = 4'h0; m_shadow = 4'h0;
        repeat (3) @(posedge clk_i);
        #1;
        test_reset();
        test_clean_frame();
        test_back_to_back();
        test_bad_separator();
        test_gap_errors();
        test_stall();
        test_reset_mid_frame();
        test_random_frames();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
